// File: rtl/mc_datapath_param.sv
// mc_datapath_param -- parametrised multi-cycle CPU datapath.
//
// Holds PC, IR, MDR, A, B and ALUOut, a 32-entry register file and the ALU.
// An external multi-cycle control FSM drives it cycle by cycle. Instruction
// and data share one memory port. The datapath supports MIPS-style R/I/J
// formats, beq/bne, j/jal/jr and lui.
//
// Parameters: XLEN (32 or 64) datapath width, RESET_PC, LINK_REG (jal target).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   Data_in             memory read data (instruction is Data_in[31:0])
//   PCWrite, Branch     unconditional PC load / beq-bne conditional load
//   IorD                mem_addr select: PC or ALUOut
//   IRWrite, RegWrite   IR load, register file write enable
//   RegDst, MemtoReg    write index and write data selects
//   ALUSrcA, ALUSrcB    ALU operand selects
//   ALU_Control         ALU operation
//   PCSource            next PC select
//   mem_addr, Data_out  memory address, store data (B)
//   inst_out, ALU_out   current IR, ALUOut register
//   zero, overflow      live ALU flags
module mc_datapath_param #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              LINK_REG = 31
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] Data_in,
  input  logic            PCWrite,
  input  logic [1:0]      Branch,
  input  logic            IorD,
  input  logic            IRWrite,
  input  logic            RegWrite,
  input  logic [1:0]      RegDst,
  input  logic [1:0]      MemtoReg,
  input  logic            ALUSrcA,
  input  logic [1:0]      ALUSrcB,
  input  logic [2:0]      ALU_Control,
  input  logic [1:0]      PCSource,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] Data_out,
  output logic [31:0]     inst_out,
  output logic [XLEN-1:0] ALU_out,
  output logic            zero,
  output logic            overflow
);

  localparam logic [4:0] LINK_IDX = 5'(LINK_REG);

  logic [XLEN-1:0] pc;
  logic [31:0]     ir;
  logic [XLEN-1:0] mdr;
  logic [XLEN-1:0] a_reg;
  logic [XLEN-1:0] b_reg;
  logic [XLEN-1:0] alu_out_q;
  logic [XLEN-1:0] rf [32];

  logic signed [XLEN-1:0] imm_sext;
  logic signed [XLEN-1:0] src_a;
  logic signed [XLEN-1:0] src_b;
  logic signed [XLEN-1:0] sum;
  logic signed [XLEN-1:0] diff;
  logic signed [XLEN-1:0] alu_res;
  logic [XLEN-1:0]        next_pc;
  logic                   pc_en;
  logic [4:0]             wr_idx;
  logic [XLEN-1:0]        wr_data;

  function automatic logic signed [XLEN-1:0] sext16(input logic [15:0] v);
    logic signed [15:0] s;
    s = v;
    return XLEN'(s);
  endfunction

  function automatic logic signed [XLEN-1:0] sext32(input logic [31:0] v);
    logic signed [31:0] s;
    s = v;
    return XLEN'(s);
  endfunction

  // ALU operand selection
  always_comb begin
    imm_sext = sext16(ir[15:0]);
    src_a    = ALUSrcA ? a_reg : pc;
    case (ALUSrcB)
      2'b00:   src_b = b_reg;
      2'b01:   src_b = XLEN'(4);
      2'b10:   src_b = imm_sext;
      default: src_b = imm_sext << 2;
    endcase
  end

  // ALU; add/sub wrap, overflow is only reported, never acted on here
  always_comb begin
    sum      = src_a + src_b;
    diff     = src_a - src_b;
    alu_res  = '0;
    overflow = 1'b0;
    case (ALU_Control)
      3'b000: alu_res = src_a & src_b;
      3'b001: alu_res = src_a | src_b;
      3'b010: begin
        alu_res  = sum;
        overflow = (src_a[XLEN-1] == src_b[XLEN-1]) && (sum[XLEN-1] != src_a[XLEN-1]);
      end
      3'b011: alu_res = src_a ^ src_b;
      3'b100: alu_res = ~(src_a | src_b);
      3'b101: alu_res = $signed($unsigned(src_b) >> ir[10:6]);
      3'b110: begin
        alu_res  = diff;
        overflow = (src_a[XLEN-1] != src_b[XLEN-1]) && (diff[XLEN-1] != src_a[XLEN-1]);
      end
      default: alu_res = (src_a < src_b) ? XLEN'(1) : '0;
    endcase
    zero = (alu_res == '0);
  end

  // Next PC; a simultaneous PCWrite and taken branch still loads once
  always_comb begin
    case (PCSource)
      2'b00:   next_pc = alu_res;
      2'b01:   next_pc = alu_out_q;
      2'b10:   next_pc = {pc[XLEN-1:28], ir[25:0], 2'b00};
      default: next_pc = a_reg;
    endcase
    pc_en = PCWrite
          | ((Branch == 2'b01) &  zero)
          | ((Branch == 2'b10) & ~zero);
  end

  // Register file write port selects
  always_comb begin
    case (RegDst)
      2'b01:   wr_idx = ir[15:11];
      2'b10:   wr_idx = LINK_IDX;
      default: wr_idx = ir[20:16];
    endcase
    case (MemtoReg)
      2'b00:   wr_data = alu_out_q;
      2'b01:   wr_data = mdr;
      2'b10:   wr_data = sext32({ir[15:0], 16'h0000});
      default: wr_data = pc;
    endcase
  end

  // Register boundary: A/B read the pre-edge IR and RF, so a same-edge
  // write shows up in A/B only one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      ir        <= '0;
      mdr       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      alu_out_q <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      mdr       <= Data_in;
      a_reg     <= rf[ir[25:21]];
      b_reg     <= rf[ir[20:16]];
      alu_out_q <= alu_res;
      if (IRWrite) ir <= Data_in[31:0];
      if (pc_en) pc <= next_pc;
      // R0 is never written, so it keeps reading zero
      if (RegWrite && (wr_idx != 5'd0)) rf[wr_idx] <= wr_data;
    end
  end

  assign mem_addr = IorD ? alu_out_q : pc;
  assign Data_out = b_reg;
  assign inst_out = ir;
  assign ALU_out  = alu_out_q;

endmodule

// File: doc/mc_datapath_param.md
Name: mc_datapath_param

Overview:
- Parametrised multi-cycle CPU datapath; next generation of the single-cycle datapath.
- Holds PC, IR, MDR, A, B, ALUOut registers, a 32-entry register file and the ALU.
- Driven cycle by cycle by an external multi-cycle control FSM.
- Shares one memory port for instruction and data; supports MIPS-style R/I/J formats, beq/bne, j/jal/jr and lui.

Parameters:
- XLEN, 32, datapath/register width. Legal values: 32 or 64. Instructions are always 32 bits.
- RESET_PC, 0, PC value after reset.
- LINK_REG, 31, destination register index for RegDst=10 (jal).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- Data_in  in  XLEN  memory read data. Instruction taken from bits [31:0].
- PCWrite  in  1  unconditional PC update.
- Branch  in  2  00 none, 01 beq (update if zero), 10 bne (update if !zero), 11 none.
- IorD  in  1  mem_addr select: 0 PC, 1 ALUOut.
- IRWrite  in  1  load IR from Data_in[31:0].
- RegWrite  in  1  register file write enable.
- RegDst  in  2  00 rt (IR[20:16]), 01 rd (IR[15:11]), 10 LINK_REG, 11 rt.
- MemtoReg  in  2  write data: 00 ALUOut, 01 MDR, 10 {IR[15:0],16'b0} sign-extended to XLEN, 11 PC.
- ALUSrcA  in  1  0 PC, 1 A.
- ALUSrcB  in  2  00 B, 01 constant 4, 10 sext(IR[15:0]), 11 sext(IR[15:0])<<2.
- ALU_Control  in  3  000 and, 001 or, 010 add, 011 xor, 100 nor, 101 srl, 110 sub, 111 slt.
- PCSource  in  2  00 live ALU result, 01 ALUOut, 10 jump target, 11 A.
- mem_addr  out  XLEN  memory address.
- Data_out  out  XLEN  store data (= B).
- inst_out  out  32  current IR.
- ALU_out  out  XLEN  ALUOut register.
- zero  out  1  live ALU result == 0.
- overflow  out  1  signed overflow of live add/sub; 0 for all other ops.

Behaviour:
- Reset (async, rst=1, any cycle including mid-instruction): PC=RESET_PC; IR, MDR, A, B, ALUOut=0; all 32 RF entries=0.
  - While reset is held: mem_addr=RESET_PC (IorD=0) or 0 (IorD=1); Data_out=0; inst_out=0; ALU_out=0.
  - Operations in progress are abandoned; no write completes on the release edge unless enables are asserted.
- Every rising edge, unconditionally: MDR<=Data_in; A<=RF[IR[25:21]]; B<=RF[IR[20:16]]; ALUOut<=live ALU result.
- IR<=Data_in[31:0] only when IRWrite=1.
- A/B read the pre-edge IR and pre-edge RF. A same-edge RF write is not visible until the following edge (old value captured).
- RF write on rising edge when RegWrite=1. A write to index 0 is discarded; R0 always reads 0.
- PC loads next_pc when PCWrite | (Branch==01 & zero) | (Branch==10 & !zero).
  - Jump target = {PC[XLEN-1:28], IR[25:0], 2'b00}.
- ALU details:
  - srl shifts srcB right logically by IR[10:6].
  - slt is a signed compare and yields 1 or 0 zero-extended.
  - add/sub wrap modulo 2^XLEN.
  - overflow is combinational and does not block writes; exception handling belongs to control.
- mem_addr and Data_out are combinational from registers, so they are valid and glitch-free once registers settle. Memory read data is expected on the same cycle (combinational or negedge RAM).
- Simultaneous PCWrite and branch condition: PC updates once, from next_pc.
- Latency: RF value to ALU = 1 cycle via A/B. ALU result to PCSource=01 or MemtoReg=00 = 1 cycle via ALUOut.

Test Plan:
- Reset mid-run: drive PC to 0x8, assert rst asynchronously between edges → PC=0x0, IR=0, ALU_out=0 immediately. RESET_PC=0x100 variant → PC=0x100.
- Fetch: Data_in=0x00221820, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALU_Control=010, PCWrite=1, PCSource=00 → after edge PC=0x4, inst_out=0x00221820, ALU_out=0x4.
- Add with overflow:
  - Preload r1=0x7FFFFFFF and r2=0x1 via MDR path (MemtoReg=01, RegDst=00, RegWrite=1).
  - Execute add $3,$1,$2 (ALUSrcA=1, ALUSrcB=00, 010) → overflow=1, ALU_out=0x80000000.
  - Writeback RegDst=01, MemtoReg=00 → r3=0x80000000.
- Branch: r1=r2=5, IR=beq offset 3, ALU sub with Branch=01, PCSource=01 (ALUOut holds PC+12) → PC updates. Same with Branch=10 → PC unchanged.
- jal/jr:
  - IR=0x0C000010, PC=0x4, PCWrite=1, PCSource=10, RegDst=10, MemtoReg=11, RegWrite=1 → PC=0x40, r31=0x4.
  - Later, IR=jr $31 with PCSource=11 → PC=0x4.
- R0 and write/read hazard:
  - RegWrite to r0 with data 0xFFFF → r0 reads 0.
  - Write r5=0xA on the same edge A captures r5 → A=old value; A=0xA after the next edge.
- XLEN=64 variant: sext(0xFFFC) → 0xFFFFFFFFFFFFFFFC; add 0x7FFF_FFFF_FFFF_FFFF+1 → overflow=1.
